// File: rtl/parking_gate_arbiter_if.sv
// Gate-side request/response and occupancy-counter signals of the parking gate arbiter.
// The slave modport is the arbiter; the master modport drives gates and counter flags.
interface parking_gate_arbiter_if #(
  parameter int unsigned N_GATES = 4,
  parameter int unsigned CNT_W   = 11
);
  logic [N_GATES-1:0] gate_req;
  logic [N_GATES-1:0] gate_dir;
  logic [N_GATES-1:0] gate_uni;
  logic               uni_is_vacated_space;
  logic               is_vacated_space;
  logic [CNT_W-1:0]   uni_parked_car;
  logic [CNT_W-1:0]   parked_car;
  logic               car_entered;
  logic               is_uni_car_entered;
  logic               car_exited;
  logic               is_uni_car_exited;
  logic [N_GATES-1:0] gate_grant;
  logic [N_GATES-1:0] gate_deny;
  logic [N_GATES-1:0] barrier_open;
  logic               busy;

  modport master (
    output gate_req, gate_dir, gate_uni,
    output uni_is_vacated_space, is_vacated_space, uni_parked_car, parked_car,
    input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
    input  gate_grant, gate_deny, barrier_open, busy
  );

  modport slave (
    input  gate_req, gate_dir, gate_uni,
    input  uni_is_vacated_space, is_vacated_space, uni_parked_car, parked_car,
    output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
    output gate_grant, gate_deny, barrier_open, busy
  );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Round-robin arbiter that turns per-gate entry/exit requests into single strobes on the
// shared occupancy counter, with a timed barrier per gate.
module parking_gate_arbiter #(
  parameter int unsigned N_GATES     = 4,
  parameter int unsigned OPEN_CYCLES = 8,
  parameter int unsigned CNT_W       = 11
) (
  input logic                   clk,
  input logic                   rst,
  parking_gate_arbiter_if.slave bus
);
  localparam int unsigned IdxW = $clog2(N_GATES);
  localparam int unsigned BarW = $clog2(OPEN_CYCLES + 1);

  typedef enum logic [1:0] {StArb, StChk, StWait} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    rr_q, rr_d, idx_q, idx_d;
  logic               dir_q, dir_d, uni_q, uni_d;
  logic [N_GATES-1:0] served_q, served_d;
  logic [BarW-1:0]    bar_cnt_q [N_GATES];
  logic [BarW-1:0]    bar_cnt_d [N_GATES];
  logic [N_GATES-1:0] grant_q, grant_d, deny_q, deny_d, open_q, open_d;
  logic               ent_q, ent_d, ent_uni_q, ent_uni_d;
  logic               ext_q, ext_d, ext_uni_q, ext_uni_d;
  logic               busy_q, busy_d;

  logic [N_GATES-1:0] eligible;
  logic               found;
  logic [IdxW-1:0]    pick, cand;
  logic               ok;

  // First eligible gate at or after rr_q, wrapping.
  always_comb begin
    eligible = bus.gate_req & ~served_q & ~open_q;
    found    = 1'b0;
    pick     = rr_q;
    cand     = rr_q;
    for (int i = 0; i < int'(N_GATES); i++) begin
      cand = IdxW'((int'(rr_q) + i) % int'(N_GATES));
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign ok = dir_q ? (uni_q ? bus.uni_is_vacated_space : bus.is_vacated_space)
                    : ((uni_q ? bus.uni_parked_car : bus.parked_car) != {CNT_W{1'b0}});

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    idx_d     = idx_q;
    dir_d     = dir_q;
    uni_d     = uni_q;
    served_d  = served_q;
    grant_d   = '0;
    deny_d    = '0;
    ent_d     = 1'b0;
    ent_uni_d = 1'b0;
    ext_d     = 1'b0;
    ext_uni_d = 1'b0;
    for (int g = 0; g < int'(N_GATES); g++) begin
      bar_cnt_d[g] = (bar_cnt_q[g] != '0) ? bar_cnt_q[g] - 1'b1 : '0;
    end

    unique case (state_q)
      StArb: begin
        if (found) begin
          idx_d   = pick;
          dir_d   = bus.gate_dir[pick];
          uni_d   = bus.gate_uni[pick];
          state_d = StChk;
        end
      end
      StChk: begin
        served_d[idx_q] = 1'b1;
        rr_d = (idx_q == IdxW'(N_GATES - 1)) ? '0 : idx_q + 1'b1;
        if (ok) begin
          grant_d[idx_q]   = 1'b1;
          ent_d            = dir_q;
          ent_uni_d        = dir_q & uni_q;
          ext_d            = ~dir_q;
          ext_uni_d        = ~dir_q & uni_q;
          bar_cnt_d[idx_q] = BarW'(OPEN_CYCLES);
          state_d          = StWait;
        end else begin
          deny_d[idx_q] = 1'b1;
          state_d       = StArb;
        end
      end
      StWait:  state_d = StArb;
      default: state_d = StArb;
    endcase

    // A dropped request always re-arms its gate, even in the cycle it is serviced.
    served_d = served_d & bus.gate_req;
    for (int g = 0; g < int'(N_GATES); g++) begin
      open_d[g] = (bar_cnt_d[g] != '0);
    end
    busy_d = (state_d != StArb);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StArb;
      rr_q      <= '0;
      idx_q     <= '0;
      dir_q     <= 1'b0;
      uni_q     <= 1'b0;
      served_q  <= '0;
      grant_q   <= '0;
      deny_q    <= '0;
      open_q    <= '0;
      ent_q     <= 1'b0;
      ent_uni_q <= 1'b0;
      ext_q     <= 1'b0;
      ext_uni_q <= 1'b0;
      busy_q    <= 1'b0;
      for (int g = 0; g < int'(N_GATES); g++) bar_cnt_q[g] <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      idx_q     <= idx_d;
      dir_q     <= dir_d;
      uni_q     <= uni_d;
      served_q  <= served_d;
      grant_q   <= grant_d;
      deny_q    <= deny_d;
      open_q    <= open_d;
      ent_q     <= ent_d;
      ent_uni_q <= ent_uni_d;
      ext_q     <= ext_d;
      ext_uni_q <= ext_uni_d;
      busy_q    <= busy_d;
      for (int g = 0; g < int'(N_GATES); g++) bar_cnt_q[g] <= bar_cnt_d[g];
    end
  end

  assign bus.gate_grant         = grant_q;
  assign bus.gate_deny          = deny_q;
  assign bus.barrier_open       = open_q;
  assign bus.car_entered        = ent_q;
  assign bus.is_uni_car_entered = ent_uni_q;
  assign bus.car_exited         = ext_q;
  assign bus.is_uni_car_exited  = ext_uni_q;
  assign bus.busy               = busy_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed and randomized checks of parking_gate_arbiter against a timestamp-based
// transaction model, plus a short run of an OPEN_CYCLES=1 instance.
module tb_parking_gate_arbiter;
  localparam int N    = 4;
  localparam int OPEN = 8;
  localparam int CW   = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  parking_gate_arbiter_if #(.N_GATES(N), .CNT_W(CW)) bus ();
  parking_gate_arbiter_if #(.N_GATES(N), .CNT_W(CW)) bus1 ();

  parking_gate_arbiter #(.N_GATES(N), .OPEN_CYCLES(OPEN), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  parking_gate_arbiter #(.N_GATES(N), .OPEN_CYCLES(1), .CNT_W(CW)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int total = 0;
  int bad   = 0;

  // Model: edge count since reset, when arbitration may next pick, in-flight request,
  // and the edge at which each barrier opened.
  int e, next_sel, pend_g, rr;
  bit pend_dir, pend_uni;
  bit served [N];
  int open_from [N];
  logic [N-1:0] x_grant, x_deny, x_open;
  logic x_ent, x_uent, x_ext, x_uext, x_busy;

  int glog_g [$];
  int glog_e [$];
  int cnt_strobe, cnt_deny, cnt_uent;
  int cnt_bar [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    e = 0; next_sel = 1; pend_g = -1; rr = 0;
    for (int g = 0; g < N; g++) begin
      served[g] = 0;
      open_from[g] = -1000;
    end
    x_grant = '0; x_deny = '0; x_open = '0;
    x_ent = 0; x_uent = 0; x_ext = 0; x_uext = 0; x_busy = 0;
  endtask

  task automatic model_edge();
    int sel;
    bit granted, ok;
    e++;
    sel = -1;
    granted = 0;
    x_grant = '0; x_deny = '0;
    x_ent = 0; x_uent = 0; x_ext = 0; x_uext = 0;
    if (pend_g < 0 && e >= next_sel) begin
      for (int k = 0; k < N; k++) begin
        int g;
        g = (rr + k) % N;
        if (sel < 0 && bus.gate_req[g] && !served[g] &&
            !((e - 1) >= open_from[g] && (e - 1) < open_from[g] + OPEN)) sel = g;
      end
    end
    if (pend_g >= 0) begin
      if (pend_dir) ok = pend_uni ? bus.uni_is_vacated_space : bus.is_vacated_space;
      else          ok = (pend_uni ? bus.uni_parked_car : bus.parked_car) != 0;
      if (ok) begin
        x_grant[pend_g] = 1'b1;
        if (pend_dir) begin x_ent = 1; x_uent = pend_uni; end
        else          begin x_ext = 1; x_uext = pend_uni; end
        open_from[pend_g] = e;
        next_sel = e + 2;
        granted = 1;
      end else begin
        x_deny[pend_g] = 1'b1;
        next_sel = e + 1;
      end
      served[pend_g] = 1;
      rr = (pend_g + 1) % N;
      pend_g = -1;
    end
    for (int g = 0; g < N; g++) if (!bus.gate_req[g]) served[g] = 0;
    if (sel >= 0) begin
      pend_g = sel;
      pend_dir = bus.gate_dir[sel];
      pend_uni = bus.gate_uni[sel];
    end
    for (int g = 0; g < N; g++) x_open[g] = (e >= open_from[g] && e < open_from[g] + OPEN);
    x_busy = (pend_g >= 0) || granted;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_grant"},   32'(bus.gate_grant),   32'(x_grant));
    chk({tag, "_deny"},    32'(bus.gate_deny),    32'(x_deny));
    chk({tag, "_barrier"}, 32'(bus.barrier_open), 32'(x_open));
    chk({tag, "_strobes"},
        32'({bus.car_entered, bus.is_uni_car_entered, bus.car_exited, bus.is_uni_car_exited}),
        32'({x_ent, x_uent, x_ext, x_uext}));
    chk({tag, "_busy"},    32'(bus.busy),         32'(x_busy));
  endtask

  task automatic clear_logs();
    glog_g.delete(); glog_e.delete();
    cnt_strobe = 0; cnt_deny = 0; cnt_uent = 0;
    for (int g = 0; g < N; g++) cnt_bar[g] = 0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all(tag);
    for (int g = 0; g < N; g++) begin
      if (bus.gate_grant[g]) begin glog_g.push_back(g); glog_e.push_back(e); end
      if (bus.barrier_open[g]) cnt_bar[g]++;
    end
    if (bus.gate_deny != '0) cnt_deny++;
    if (bus.car_entered || bus.car_exited) cnt_strobe++;
    if (bus.is_uni_car_entered) cnt_uent++;
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    compare_all(tag);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic set_req(input int g, input bit r, input bit d, input bit u);
    bus.gate_req[g] = r;
    bus.gate_dir[g] = d;
    bus.gate_uni[g] = u;
  endtask

  task automatic drive_random();
    for (int g = 0; g < N; g++) begin
      if (bus.gate_req[g]) begin
        if ($urandom_range(5) == 0) bus.gate_req[g] = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        set_req(g, 1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
    end
    bus.uni_is_vacated_space = 1'($urandom_range(1));
    bus.is_vacated_space     = 1'($urandom_range(1));
    bus.uni_parked_car = ($urandom_range(1) != 0) ? CW'($urandom_range(7)) : '0;
    bus.parked_car     = ($urandom_range(1) != 0) ? CW'($urandom_range(7)) : '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int n_bar, n_grant, n_busy, n_both;
    bus.gate_req = '0; bus.gate_dir = '0; bus.gate_uni = '0;
    bus.uni_is_vacated_space = 1'b1; bus.is_vacated_space = 1'b1;
    bus.uni_parked_car = '0; bus.parked_car = '0;
    bus1.gate_req = '0; bus1.gate_dir = '0; bus1.gate_uni = '0;
    bus1.uni_is_vacated_space = 1'b1; bus1.is_vacated_space = 1'b1;
    bus1.uni_parked_car = '0; bus1.parked_car = '0;

    // Single uni entry held: one grant, one strobe, barrier open OPEN cycles.
    do_reset("t1_rst");
    set_req(0, 1, 1, 1);
    steps("t1", 2);
    chk("t1_grant0", 32'(bus.gate_grant), 32'h1);
    chk("t1_uni_entered", 32'({bus.car_entered, bus.is_uni_car_entered}), 32'h3);
    steps("t1", 12);
    chk("t1_bar_cycles", 32'(cnt_bar[0]), 32'(OPEN));
    chk("t1_one_strobe", 32'(cnt_strobe), 32'd1);
    set_req(0, 0, 1, 1);
    step("t1");

    // Four simultaneous public entries: round robin at 3-cycle spacing.
    do_reset("t2_rst");
    for (int g = 0; g < N; g++) set_req(g, 1, 1, 0);
    steps("t2", 14);
    chk("t2_ngrants", 32'(glog_g.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_order%0d", k), 32'((k < glog_g.size()) ? glog_g[k] : -1), 32'(k));
      chk($sformatf("t2_edge%0d", k),  32'((k < glog_e.size()) ? glog_e[k] : -1), 32'(2 + 3 * k));
    end
    chk("t2_strobes", 32'(cnt_strobe), 32'd4);
    chk("t2_no_uni", 32'(cnt_uent), 32'd0);
    bus.gate_req = '0;
    step("t2");

    // Exit with empty lot is denied once; retry after re-raise succeeds.
    do_reset("t3_rst");
    bus.parked_car = '0;
    set_req(2, 1, 0, 0);
    steps("t3", 2);
    chk("t3_deny2", 32'(bus.gate_deny), 32'h4);
    steps("t3", 10);
    chk("t3_one_deny", 32'(cnt_deny), 32'd1);
    chk("t3_no_strobe", 32'(cnt_strobe), 32'd0);
    set_req(2, 0, 0, 0);
    step("t3");
    bus.parked_car = CW'(5);
    set_req(2, 1, 0, 0);
    steps("t3", 2);
    chk("t3_grant2", 32'(bus.gate_grant), 32'h4);
    chk("t3_exited", 32'({bus.car_exited, bus.is_uni_car_exited}), 32'h2);
    set_req(2, 0, 0, 0);
    step("t3");

    // Uni entry denied, public entry granted right after; pointer wraps to gate 0.
    do_reset("t4_rst");
    bus.uni_is_vacated_space = 1'b0;
    bus.is_vacated_space = 1'b1;
    set_req(1, 1, 1, 1);
    set_req(3, 1, 1, 0);
    steps("t4", 6);
    chk("t4_deny_cnt", 32'(cnt_deny), 32'd1);
    chk("t4_grant3", 32'((glog_g.size() > 0) ? glog_g[0] : -1), 32'd3);
    chk("t4_grant3_edge", 32'((glog_e.size() > 0) ? glog_e[0] : -1), 32'd4);
    bus.gate_req = '0;
    steps("t4", 10);
    set_req(0, 1, 1, 0);
    set_req(1, 1, 1, 0);
    steps("t4", 2);
    chk("t4_rr_wrap", 32'(bus.gate_grant), 32'h1);
    bus.gate_req = '0;
    steps("t4", 4);

    // Reset while in CHK aborts the request.
    do_reset("t5_rst");
    bus.uni_is_vacated_space = 1'b1;
    set_req(0, 1, 1, 0);
    step("t5");
    bus.gate_req = '0;
    do_reset("t5_midrst");
    steps("t5", 4);
    chk("t5_no_grant", 32'(glog_g.size()), 32'd0);
    chk("t5_no_strobe", 32'(cnt_strobe), 32'd0);
    set_req(0, 1, 1, 0);
    set_req(2, 1, 1, 0);
    steps("t5", 2);
    chk("t5_from_gate0", 32'(bus.gate_grant), 32'h1);
    bus.gate_req = '0;
    steps("t5", 3);

    // Randomized traffic and counter state.
    do_reset("rnd_rst");
    for (int i = 0; i < 400; i++) begin
      drive_random();
      step("rnd");
    end
    bus.gate_req = '0;

    // OPEN_CYCLES=1 instance: barrier coincides with each grant.
    n_bar = 0; n_grant = 0; n_busy = 0; n_both = 0;
    bus1.gate_req[0] = 1'b1;
    bus1.gate_dir[0] = 1'b1;
    for (int i = 0; i < 19; i++) begin
      if (i == 8) bus1.gate_req[0] = 1'b0;
      if (i == 11) bus1.gate_req[0] = 1'b1;
      @(negedge clk);
      if (bus1.barrier_open[0]) n_bar++;
      if (bus1.gate_grant[0]) n_grant++;
      if (bus1.busy) n_busy++;
      if (bus1.barrier_open[0] && bus1.gate_grant[0]) n_both++;
    end
    chk("t6_grants", 32'(n_grant), 32'd2);
    chk("t6_bar_cycles", 32'(n_bar), 32'd2);
    chk("t6_bar_with_grant", 32'(n_both), 32'd2);
    chk("t6_busy_cycles", 32'(n_busy), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
